// File: rtl/adc_seq_pkg.sv
// Shared state encoding and sizing helpers for the ADC conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CNV  = 4'd1,
    ST_BUSY = 4'd2,
    ST_SPI  = 4'd3,
    ST_ACC  = 4'd4,
    ST_WAIT = 4'd5
  } state_t;

  localparam int STATE_W = 4;

  function automatic logic [STATE_W-1:0] state_code(input state_t s);
    return s;
  endfunction

  // Headroom for 2^max_osr summed samples without overflow.
  function automatic int acc_width(input int dw, input int max_osr);
    return dw + max_osr;
  endfunction

endpackage

// File: rtl/adc_acc_ch.sv
// One channel of the oversampling averager: sign-extend, accumulate, and
// emit the block sum arithmetically shifted right by the oversampling exponent.
module adc_acc_ch
  import adc_seq_pkg::*;
#(
  parameter int DW           = 24,
  parameter int MAX_OSR_LOG2 = 4,
  parameter int OW           = $clog2(MAX_OSR_LOG2 + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_add,
  input  logic          i_last,
  input  logic [OW-1:0] i_osr,
  input  logic [DW-1:0] i_sample,
  output logic [DW-1:0] o_avg
);

  localparam int AW = acc_width(DW, MAX_OSR_LOG2);

  logic signed [AW-1:0] r_acc;
  logic        [DW-1:0] r_avg;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_shift;

  // Running sum including the current sample, and its averaged form
  always_comb begin
    w_sum   = r_acc + AW'($signed(i_sample));
    w_shift = w_sum >>> i_osr;
  end

  // Accumulator and averaged-output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_avg <= '0;
    end else if (i_add && i_last) begin
      r_acc <= '0;
      r_avg <= w_shift[DW-1:0];
    end else if (i_add) begin
      r_acc <= w_sum;
    end else if (i_clr) begin
      r_acc <= '0;
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/adc_cnv_seq.sv
// ADC conversion sequencer: CNV strobe, BUSY wait with timeout, SPI readout
// and per-channel oversampling average, one averaged set per block.
module adc_cnv_seq
  import adc_seq_pkg::*;
#(
  parameter int CH           = 8,
  parameter int DW           = 24,
  parameter int MAX_OSR_LOG2 = 4,
  parameter int CNV_PW       = 4,
  parameter int BUSY_TO      = 1000
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_en,
  input  logic [31:0]                        i_cyc_t,
  input  logic [$clog2(MAX_OSR_LOG2+1)-1:0]  i_osr_log2,
  input  logic                               i_adc_busy,
  output logic                               o_adc_cnv,
  output logic                               o_adc_spi_start,
  input  logic                               i_adc_spi_done,
  input  logic [CH*DW-1:0]                   i_adc_data,
  output logic [CH*DW-1:0]                   o_data,
  output logic                               o_data_valid,
  output logic [31:0]                        o_sample_cnt,
  output logic                               o_timeout,
  output logic                               o_overrun,
  input  logic                               i_clr_flags,
  output logic [3:0]                         o_state
);

  localparam int OW = $clog2(MAX_OSR_LOG2 + 1);
  localparam int BW = MAX_OSR_LOG2 + 1;
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam int PW = $clog2(CNV_PW + 1);

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_cnv_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic [31:0]      r_per;
  logic             r_wait_first;
  logic [BW-1:0]    r_blk;
  logic [OW-1:0]    r_osr;
  logic [CH*DW-1:0] r_raw;
  logic             r_cnv;
  logic             r_spi_start;
  logic             r_valid;
  logic [31:0]      r_cnt;
  logic             r_timeout;
  logic             r_overrun;
  logic [3:0]       r_state_o;

  logic [OW-1:0]    w_osr_clamp;
  logic [31:0]      w_thr;
  logic [BW-1:0]    w_blk_inc;
  logic             w_last;
  logic             w_to_evt;
  logic             w_ovr_evt;
  logic             w_acc_clr;
  logic             w_acc_add;
  logic [CH*DW-1:0] w_avg;

  assign w_osr_clamp = (i_osr_log2 > OW'(MAX_OSR_LOG2)) ? OW'(MAX_OSR_LOG2) : i_osr_log2;
  // A zero period behaves like a period of one cycle.
  assign w_thr       = (i_cyc_t == 32'd0) ? 32'd0 : (i_cyc_t - 32'd1);
  assign w_blk_inc   = r_blk + BW'(1);
  assign w_last      = (w_blk_inc == (BW'(1) << r_osr));
  assign w_acc_clr   = (r_state == ST_IDLE) && i_en;
  assign w_acc_add   = (r_state == ST_ACC);
  assign w_to_evt    = (r_state == ST_BUSY) && i_adc_busy && (r_to_cnt == TW'(BUSY_TO - 1));
  assign w_ovr_evt   = (r_state == ST_WAIT) && r_wait_first && i_en && (r_per >= w_thr);

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_en) w_next = ST_CNV; else w_next = ST_IDLE;
      ST_CNV:  if (r_cnv_cnt == PW'(CNV_PW - 1)) w_next = ST_BUSY; else w_next = ST_CNV;
      ST_BUSY: begin
        if (!i_adc_busy)   w_next = ST_SPI;
        else if (w_to_evt) w_next = ST_WAIT;
        else               w_next = ST_BUSY;
      end
      ST_SPI:  if (i_adc_spi_done) w_next = ST_ACC; else w_next = ST_SPI;
      ST_ACC:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (!i_en)               w_next = ST_IDLE;
        else if (r_per >= w_thr) w_next = ST_CNV;
        else                     w_next = ST_WAIT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // CNV width, BUSY timeout and period counters; period restarts on CNV entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnv_cnt    <= '0;
      r_to_cnt     <= '0;
      r_per        <= '0;
      r_wait_first <= 1'b0;
    end else begin
      r_cnv_cnt    <= (r_state == ST_CNV)  ? r_cnv_cnt + PW'(1) : '0;
      r_to_cnt     <= (r_state == ST_BUSY) ? r_to_cnt + TW'(1)  : '0;
      r_wait_first <= (w_next == ST_WAIT) && (r_state != ST_WAIT);
      if ((w_next == ST_CNV) && (r_state != ST_CNV)) r_per <= '0;
      else if (r_per != 32'hFFFF_FFFF)               r_per <= r_per + 32'd1;
      else                                           r_per <= r_per;
    end
  end

  // Block bookkeeping: oversampling exponent, block counter, captured samples
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_osr <= '0;
      r_blk <= '0;
      r_raw <= '0;
    end else begin
      if (w_acc_clr || (w_acc_add && w_last)) begin
        r_osr <= w_osr_clamp;
        r_blk <= '0;
      end else if (w_acc_add) begin
        r_blk <= w_blk_inc;
      end
      if ((r_state == ST_SPI) && i_adc_spi_done) r_raw <= i_adc_data;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    adc_acc_ch #(
      .DW           (DW),
      .MAX_OSR_LOG2 (MAX_OSR_LOG2),
      .OW           (OW)
    ) u_acc (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (w_acc_clr),
      .i_add    (w_acc_add),
      .i_last   (w_last),
      .i_osr    (r_osr),
      .i_sample (r_raw[g*DW +: DW]),
      .o_avg    (w_avg[g*DW +: DW])
    );
  end

  // Registered strobes, counters and sticky flags (a new event beats a clear)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnv       <= 1'b0;
      r_spi_start <= 1'b0;
      r_valid     <= 1'b0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_state_o   <= '0;
    end else begin
      r_cnv       <= (w_next == ST_CNV);
      r_spi_start <= (r_state == ST_BUSY) && (w_next == ST_SPI);
      r_valid     <= w_acc_add && w_last;
      r_state_o   <= state_code(w_next);
      if (w_acc_add && w_last) r_cnt <= r_cnt + 32'd1;
      r_timeout   <= w_to_evt  ? 1'b1 : (i_clr_flags ? 1'b0 : r_timeout);
      r_overrun   <= w_ovr_evt ? 1'b1 : (i_clr_flags ? 1'b0 : r_overrun);
    end
  end

  assign o_adc_cnv       = r_cnv;
  assign o_adc_spi_start = r_spi_start;
  assign o_data          = w_avg;
  assign o_data_valid    = r_valid;
  assign o_sample_cnt    = r_cnt;
  assign o_timeout       = r_timeout;
  assign o_overrun       = r_overrun;
  assign o_state         = r_state_o;

endmodule
